// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and lane/byte-enable helpers used by the LSU modules.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_ok(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Lane offset with the offending low bits cleared (forced alignment).
    function automatic logic [1:0] align_off(input logic [2:0] f3,
                                             input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return {a[1], 1'b0};
            2'b10:   return 2'b00;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] f3,
                                           input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

    // Replication places the datum on every lane it could target.
    function automatic logic [31:0] lane_data(input logic [2:0] f3,
                                              input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects the addressed byte/half of the read word and
// sign- or zero-extends it. Ports: rdata (word), off (lane), funct3, data.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'h0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store unit between execute and data memory (req/gnt + rvalid port).
// Ports: req_* core request, rsp_* one-cycle response, mem_* memory side.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses respond with an error
// instead of being forced to alignment.
module data_mem_access_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW =
        (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Timeout fires on the edge where the counter would reach TIMEOUT_CYC.
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e    state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   load_data;
    logic [1:0]    off_in;
    logic          trap;
    logic          acc_ok;
    logic          timeout;

    assign req_ready = (state == IDLE);
    assign off_in    = align_off(req_funct3, req_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign acc_ok  = f3_ok(req_we, req_funct3) && !trap;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (acc_ok) begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= calc_be(req_funct3, off_in);
                            mem_wdata <= lane_data(req_funct3, req_wdata);
                            f3_q      <= req_funct3;
                            off_q     <= off_in;
                        end else begin
                            // Rejected without touching memory.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                REQ: begin
                    // Grant beats a coincident timeout; rvalid is ignored here.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (mem_we) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end else if (timeout) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed vector table,
// reset/idle corner sequences and randomized accesses against a model.
module tb_data_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    data_mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          gd;
        int          rd;
        bit          stray;
        exp_t        e;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic        r_rdy, r_seen, r_we, r_stable, r_drop_ok, r_err, r_rdy_after;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    int          r_nreq, r_lat, r_npulse;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: derived from access size, byte lanes and cycle counting.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] mrd, input int gd,
                                   input int rd);
        exp_t e;
        int size, off;
        bit ok, mis;
        logic [31:0] ext;
        e = '{req: 1'b0, addr: '0, be: '0, wdata: '0, lat: 0,
              rdata: '0, err: 1'b0};
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = (int'(a[1:0]) % size) != 0;
`ifdef MISALIGN_TRAP_EN
        if (mis) ok = 1'b0;
`else
        if (mis) ok = ok;
`endif
        if (!ok) begin
            e.lat = 1;
            e.err = 1'b1;
            return e;
        end
        off = (int'(a[1:0]) / size) * size;
        e.req = 1'b1;
        e.addr = a - 32'(int'(a[1:0]));
        for (int i = 0; i < size; i++) e.be[off+i] = 1'b1;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i%size) +: 8];
        if (gd < 0) begin
            e.lat = 1 + TO;
            e.err = 1'b1;
        end else if (we) begin
            e.lat = gd + 2;
        end else if (rd < 0 || rd > TO) begin
            e.lat = gd + 1 + TO + 1;
            e.err = 1'b1;
        end else begin
            e.lat = gd + rd + 2;
            ext = mrd >> (8 * off);
            if (size < 4) begin
                ext = ext & ((32'd1 << (8 * size)) - 32'd1);
                if (!f3[2] && ext >= (32'd1 << (8 * size - 1)))
                    ext = ext - (32'd1 << (8 * size));
            end
            e.rdata = ext;
        end
        return e;
    endfunction

    // One access; the bench plays the memory (gnt after gd extra req cycles,
    // rvalid rd cycles after gnt; negative = never).
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] mrd, input int gd,
                              input int rd, input bit stray);
        int gk;
        gk = 0;
        r_seen = 0; r_stable = 1; r_drop_ok = 1; r_nreq = 0; r_lat = 0;
        r_npulse = 0; r_rdata = '0; r_err = 0; r_rdy_after = 0;
        r_addr = '0; r_we = 0; r_be = '0; r_wdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        r_rdy = req_ready;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (gk > 0 && k == gk + 1 && mem_req) r_drop_ok = 0;
            if (mem_req) begin
                if (!r_seen) begin
                    r_seen = 1; r_addr = mem_addr; r_we = mem_we;
                    r_be = mem_be; r_wdata = mem_wdata;
                end else if (mem_addr !== r_addr || mem_we !== r_we ||
                             mem_be !== r_be || mem_wdata !== r_wdata) begin
                    r_stable = 0;
                end
                r_nreq++;
                if (gd >= 0 && r_nreq == gd + 1) begin
                    mem_gnt = 1'b1;
                    gk = k;
                    if (stray) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = ~mrd;
                    end
                end
            end
            if (gk > 0 && !we && rd > 0 && k == gk + rd) begin
                mem_rvalid = 1'b1;
                mem_rdata = mrd;
            end
            if (rsp_valid) begin
                r_npulse++;
                if (r_lat == 0) begin
                    r_lat = k; r_rdata = rsp_rdata; r_err = rsp_err;
                end
            end
            if (r_lat != 0 && k == r_lat + 1) r_rdy_after = req_ready;
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic compare(input string tag, input logic we, input exp_t e);
        check({tag, ".ready"}, 32'(r_rdy), 32'd1);
        check({tag, ".memreq"}, 32'(r_seen), 32'(e.req));
        if (e.req) begin
            check({tag, ".addr"}, r_addr, e.addr);
            check({tag, ".we"}, 32'(r_we), 32'(we));
            check({tag, ".be"}, 32'(r_be), 32'(e.be));
            if (we) check({tag, ".wdata"}, r_wdata, e.wdata);
            check({tag, ".stable"}, 32'(r_stable), 32'd1);
            check({tag, ".req_drop"}, 32'(r_drop_ok), 32'd1);
        end
        check({tag, ".lat"}, 32'(r_lat), 32'(e.lat));
        check({tag, ".rdata"}, r_rdata, e.rdata);
        check({tag, ".err"}, 32'(r_err), 32'(e.err));
        check({tag, ".pulses"}, 32'(r_npulse), 32'd1);
        check({tag, ".ready_after"}, 32'(r_rdy_after), 32'd1);
    endtask

    function automatic vec_t mkv(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] mrd, input int gd,
                                 input int rd, input bit stray,
                                 input logic req, input logic [31:0] eaddr,
                                 input logic [3:0] be, input logic [31:0] ewd,
                                 input int lat, input logic [31:0] erd,
                                 input logic err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.mrd = mrd;
        v.gd = gd; v.rd = rd; v.stray = stray;
        v.e = '{req: req, addr: eaddr, be: be, wdata: ewd, lat: lat,
                rdata: erd, err: err};
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int cnt;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, mrd;
        int          gd, rd;
        bit          stray;
        exp_t        e;

        rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; mem_gnt = 0; mem_rvalid = 0;
        mem_rdata = 0;

        // Directed table
        vecs[0]  = mkv(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 1, 0,
                       1, 32'h100, 4'b1000, 0, 3, 32'hFFFF_FF80, 0);
        vecs[1]  = mkv(0, 3'b101, 32'h102, 0, 32'hBEEF_0000, 0, 1, 0,
                       1, 32'h100, 4'b1100, 0, 3, 32'h0000_BEEF, 0);
        vecs[2]  = mkv(0, 3'b001, 32'h102, 0, 32'hBEEF_0000, 1, 2, 0,
                       1, 32'h100, 4'b1100, 0, 5, 32'hFFFF_BEEF, 0);
        vecs[3]  = mkv(1, 3'b000, 32'h201, 32'h0000_00AB, 0, 5, 1, 0,
                       1, 32'h200, 4'b0010, 32'hABAB_ABAB, 7, 0, 0);
`ifdef MISALIGN_TRAP_EN
        vecs[4]  = mkv(1, 3'b010, 32'h302, 32'h1234_5678, 0, 0, 1, 0,
                       0, 0, 0, 0, 1, 0, 1);
        vecs[10] = mkv(0, 3'b001, 32'h103, 0, 32'h7FFF_0000, 0, 1, 0,
                       0, 0, 0, 0, 1, 0, 1);
`else
        vecs[4]  = mkv(1, 3'b010, 32'h302, 32'h1234_5678, 0, 0, 1, 0,
                       1, 32'h300, 4'hF, 32'h1234_5678, 2, 0, 0);
        vecs[10] = mkv(0, 3'b001, 32'h103, 0, 32'h7FFF_0000, 0, 1, 0,
                       1, 32'h100, 4'b1100, 0, 3, 32'h0000_7FFF, 0);
`endif
        vecs[5]  = mkv(0, 3'b011, 32'h10, 0, 0, 0, 1, 0,
                       0, 0, 0, 0, 1, 0, 1);
        vecs[6]  = mkv(1, 3'b100, 32'h10, 32'hFF, 0, 0, 1, 0,
                       0, 0, 0, 0, 1, 0, 1);
        vecs[7]  = mkv(1, 3'b001, 32'h106, 32'h0000_BEEF, 0, 2, 1, 0,
                       1, 32'h104, 4'b1100, 32'hBEEF_BEEF, 4, 0, 0);
        vecs[8]  = mkv(0, 3'b100, 32'h101, 0, 32'h0000_8000, 0, 3, 0,
                       1, 32'h100, 4'b0010, 0, 5, 32'h0000_0080, 0);
        vecs[9]  = mkv(0, 3'b010, 32'h108, 0, 32'hDEAD_BEEF, 0, 1, 1,
                       1, 32'h108, 4'hF, 0, 3, 32'hDEAD_BEEF, 0);
        vecs[11] = mkv(1, 3'b010, 32'h10, 32'hCAFE_F00D, 0, -1, 1, 0,
                       1, 32'h10, 4'hF, 32'hCAFE_F00D, 1 + TO, 0, 1);
        vecs[12] = mkv(0, 3'b010, 32'h20, 0, 32'h1111_2222, 0, TO + 2, 0,
                       1, 32'h20, 4'hF, 0, TO + 2, 0, 1);

        // Reset state
        #2;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                       vecs[i].mrd, vecs[i].gd, vecs[i].rd, vecs[i].stray);
            compare($sformatf("vec%0d", i), vecs[i].we, vecs[i].e);
            if (i == 11) check("vec11.req_cycles", 32'(r_nreq), 32'(TO));
        end

        // gnt/rvalid while idle must be ignored
        @(negedge clk);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || mem_req) cnt++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("idle_ignore.activity", 32'(cnt), 32'd0);
        check("idle_ignore.ready", 32'(req_ready), 32'd1);

        // Reset while in REQ: mem_req drops asynchronously
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h400; req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_req.mem_req_up", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_req.mem_req", 32'(mem_req), 32'd0);
        check("rst_req.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in WAIT: later rvalid yields no response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_wait.in_wait", 32'({mem_req, req_ready}), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_wait.mem_req", 32'(mem_req), 32'd0);
        check("rst_wait.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid) cnt++;
        end
        check("rst_wait.no_rsp", 32'(cnt), 32'd0);
        check("rst_wait.ready", 32'(req_ready), 32'd1);

        // Randomized accesses against the model
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = $urandom; wd = $urandom; mrd = $urandom;
            gd = $urandom_range(0, 5);
            rd = $urandom_range(1, 5);
            stray = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) gd = -1;
            if ($urandom_range(0, 15) == 0) rd = TO + 2;
            e = model(we, f3, a, wd, mrd, gd, rd);
            run_access(we, f3, a, wd, mrd, gd, rd, stray);
            compare($sformatf("rnd%0d", n), we, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
